psa_accum: RTL and testbench
============================

PSA_ACCUM -- requirements
Module: psa_accum

Interface
REQ-001 Parameter NUM_WORDS, default 4, is the number of accepted input beats per packet; legal range 1..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clr  input  1  synchronous abort; discards the packet in progress.
REQ-005 in_valid  input  1  in_sum/in_err are valid this cycle.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_sum  input  16  partitioned sum word from the upstream 4-lane adder; lane i = bits [4i+3:4i], 4-bit signed.
REQ-008 in_err  input  1  upstream lane-overflow flag for this beat.
REQ-009 out_valid  output  1  result/err are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  16  signed reduction of all lanes over the packet.
REQ-012 err  output  1  sticky packet error.

Function
REQ-013 The beat handshake SHALL be in_valid & in_ready; the result handshake SHALL be out_valid & out_ready.
REQ-014 FSM states SHALL be IDLE, ACCUM, REDUCE and DONE; in_ready=1 only in IDLE and ACCUM; out_valid=1 only in DONE.
REQ-015 IDLE: on an accepted beat, load the lanes with the sign-extended beat and set beat count=1; go to ACCUM, or to REDUCE if NUM_WORDS=1.
REQ-016 ACCUM: each accepted beat SHALL add each sign-extended 4-bit lane into its own 6-bit signed lane accumulator; after beat NUM_WORDS go to REDUCE.
REQ-017 Cycles with in_valid=0 SHALL leave all state unchanged.
REQ-018 REDUCE: in exactly one cycle, register result = sum of the four lane accumulators, each sign-extended to 16 bits; go to DONE.
REQ-019 out_valid SHALL rise two cycles after the cycle in which the last beat is accepted.
REQ-020 DONE: result and err SHALL hold stable while out_ready=0; on the handshake go to IDLE, with in_ready=1 in the following cycle.
REQ-021 Lane overflow is a 6-bit signed add leaving -32..31; handling is per REQ-029/REQ-030, and it SHALL always set err.
REQ-022 err SHALL be the OR of in_err over all accepted beats and all lane overflows in the packet; it is cleared on entry to a new packet.
REQ-023 clr SHALL force IDLE and clear the lanes, count, result and err on the next edge, in any state; a beat presented with clr=1 SHALL be dropped.
REQ-024 rst SHALL take priority over clr; clr SHALL take priority over the handshakes.

Reset
REQ-025 On rst: state=IDLE, lanes=0, count=0, result=16'h0000, err=0, out_valid=0, in_ready=1 from the first cycle after reset.
REQ-026 rst asserted mid-packet or in DONE SHALL discard all work; no out_valid SHALL be produced for that packet.
REQ-027 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from in_* to out_*.

Configuration
REQ-028 Macro PSA_ACCUM_SAT_EN SHALL select the lane overflow behaviour.
REQ-029 Defined: an overflowing lane SHALL clamp to +31 or -32 and stay clamped for further adds of the same sign.
REQ-030 Undefined: lanes SHALL wrap modulo 64 (two's complement).

Verification
REQ-031 NUM_WORDS=4, four beats of 16'h1111, in_err=0 -> result=16'h0010, err=0; out_valid 2 cycles after beat 4.
REQ-032 NUM_WORDS=4, four beats of 16'h8888 -> lanes=-32 each, result=16'hFF80, err=0 (exact boundary, no overflow).
REQ-033 NUM_WORDS=16, sixteen beats of 16'h7777 -> SAT_EN: result=16'h007C, err=1; without SAT_EN: result=16'hFFC0, err=1.
REQ-034 NUM_WORDS=4, beats of 16'h1111 with in_err=1 on beat 2 only and gaps of in_valid=0 -> result=16'h0010, err=1.
REQ-035 Hold out_ready=0 for 3 cycles in DONE -> out_valid, result and err stable, in_ready=0; handshake then IDLE.
REQ-036 Pulse clr after beat 2, then send a fresh 4-beat packet of 16'h2222 -> result=16'h0020, err=0; same sequence with rst in place of clr gives the same result.

Source files
------------

// File: rtl/psa_accum.sv
// psa_accum: packet accumulator that reduces 4-lane partitioned sums into one signed total
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clr                 synchronous abort of the packet in progress
//   in_valid/in_ready   beat handshake for in_sum (4 x 4-bit signed lanes) and in_err
//   out_valid/out_ready result handshake for result (16-bit signed) and sticky err
// Parameter NUM_WORDS (1..16) sets the number of beats per packet.
// Define PSA_ACCUM_SAT_EN for saturating lane accumulators; otherwise lanes wrap.
module psa_accum #(
   parameter int NUM_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_sum,
   input  logic        in_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;
   state_t      state, state_nx;
   logic [5:0]  lane [4];
   logic [5:0]  sext [4];
   logic [5:0]  added [4];
   logic [3:0]  ovf;
   logic [4:0]  cnt;
   logic        beat;
   // returns {overflow, new lane value}; overflow means the true sum left -32..31
   function automatic logic [6:0] lane_add(input logic [5:0] a, input logic [3:0] b);
      logic [6:0] s;
      logic [5:0] v;
      logic       o;
      s = {a[5], a} + {{3{b[3]}}, b};
      o = s[6] ^ s[5];
`ifdef PSA_ACCUM_SAT_EN
      v = o ? (s[6] ? 6'h20 : 6'h1F) : s[5:0];
`else
      v = s[5:0];
`endif
      return {o, v};
   endfunction
   function automatic logic [15:0] sx16(input logic [5:0] a);
      return {{10{a[5]}}, a};
   endfunction
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign sext[i] = {{2{in_sum[4*i+3]}}, in_sum[4*i+:4]};
      assign {ovf[i], added[i]} = lane_add(lane[i], in_sum[4*i+:4]);
   end
   assign beat = in_valid & in_ready;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (beat) state_nx = (NUM_WORDS == 1) ? REDUCE : ACCUM;
         ACCUM:  if (beat && cnt == 5'(NUM_WORDS - 1)) state_nx = REDUCE;
         REDUCE: state_nx = DONE;
         DONE:   if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (clr) state_nx = IDLE;
   end
   always_comb begin
      in_ready  = (state == IDLE) || (state == ACCUM);
      out_valid = (state == DONE);
   end
   // the first beat of a packet loads the lanes and restarts err
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int k = 0; k < 4; k++) lane[k] <= '0;
         cnt    <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         if (beat) begin
            for (int k = 0; k < 4; k++) lane[k] <= (state == IDLE) ? sext[k] : added[k];
            cnt <= (state == IDLE) ? 5'd1 : cnt + 5'd1;
            err <= ((state == IDLE) ? 1'b0 : (err | (|ovf))) | in_err;
         end
         if (state == REDUCE) result <= sx16(lane[0]) + sx16(lane[1]) + sx16(lane[2]) + sx16(lane[3]);
      end
   end
endmodule

// File: tb/tb_psa_accum.sv
// tb_psa_accum: scoreboard bench for psa_accum with 4-beat and 16-beat instances
module tb_psa_accum;
   logic        clk = 0, rst = 1, clr = 0, in_err = 0, out_ready = 1;
   logic        in_valid4 = 0, in_valid16 = 0;
   logic [15:0] in_sum = '0;
   logic        in_ready4, in_ready16, out_valid4, out_valid16, err4, err16;
   logic [15:0] result4, result16;
   logic [16:0] q4[$], q16[$];
   logic [16:0] e4, e16;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   psa_accum #(.NUM_WORDS(4)) dut4 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_sum(in_sum), .in_err(in_err), .out_valid(out_valid4), .out_ready(out_ready),
      .result(result4), .err(err4));

   psa_accum #(.NUM_WORDS(16)) dut16 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid16), .in_ready(in_ready16),
      .in_sum(in_sum), .in_err(in_err), .out_valid(out_valid16), .out_ready(out_ready),
      .result(result16), .err(err16));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor: pops the expected response whenever a result handshake occurs
   always @(negedge clk) begin
      if (!rst && out_valid4 && out_ready) begin
         if (q4.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut4 unexpected output: result %h err %b", result4, err4);
         end else begin
            e4 = q4.pop_front();
            check("dut4 result", 32'(result4), 32'(e4[15:0]));
            check("dut4 err", 32'(err4), 32'(e4[16]));
         end
      end
      if (!rst && out_valid16 && out_ready) begin
         if (q16.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut16 unexpected output: result %h err %b", result16, err16);
         end else begin
            e16 = q16.pop_front();
            check("dut16 result", 32'(result16), 32'(e16[15:0]));
            check("dut16 err", 32'(err16), 32'(e16[16]));
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit big, input logic [15:0] s, input logic e);
      int n = 0;
      while (!(big ? in_ready16 : in_ready4) && n < 20) begin
         tick();
         n++;
      end
      check("in_ready wait", 32'(n < 20), 32'd1);
      in_sum = s;
      in_err = e;
      if (big) in_valid16 = 1; else in_valid4 = 1;
      tick();
      in_valid4 = 0;
      in_valid16 = 0;
      in_err = 0;
   endtask

   task automatic wait_done(input bit big);
      int n = 0;
      while (!(big ? out_valid16 : out_valid4) && n < 20) begin
         tick();
         n++;
      end
      check("out_valid wait", 32'(n < 20), 32'd1);
      tick();
   endtask

   initial begin
      tick(2);
      rst = 0;
      check("reset in_ready", 32'(in_ready4), 32'd1);
      check("reset out_valid", 32'(out_valid4), 32'd0);
      check("reset result", 32'(result4), 32'h0);
      check("reset err", 32'(err4), 32'd0);
      check("reset in_ready16", 32'(in_ready16), 32'd1);

      // four beats of 1111: lanes 4 each, total 16; out_valid two cycles after last beat
      q4.push_back({1'b0, 16'h0010});
      repeat (4) beat(0, 16'h1111, 0);
      check("latency cycle1 out_valid", 32'(out_valid4), 32'd0);
      tick();
      check("latency cycle2 out_valid", 32'(out_valid4), 32'd1);
      tick();
      check("post handshake in_ready", 32'(in_ready4), 32'd1);
      check("post handshake out_valid", 32'(out_valid4), 32'd0);

      // exact negative boundary: lanes reach -32 without overflow
      q4.push_back({1'b0, 16'hFF80});
      repeat (4) beat(0, 16'h8888, 0);
      wait_done(0);

      // in_err on beat 2 with idle gaps
      q4.push_back({1'b1, 16'h0010});
      beat(0, 16'h1111, 0);
      tick(2);
      beat(0, 16'h1111, 1);
      tick();
      beat(0, 16'h1111, 0);
      beat(0, 16'h1111, 0);
      wait_done(0);

      // back-pressure in DONE: lanes 4,3,2,1 x4 -> 16+12+8+4 = 40
      out_ready = 0;
      q4.push_back({1'b0, 16'h0028});
      repeat (4) beat(0, 16'h1234, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("hold out_valid", 32'(out_valid4), 32'd1);
         check("hold result", 32'(result4), 32'h0028);
         check("hold err", 32'(err4), 32'd0);
         check("hold in_ready", 32'(in_ready4), 32'd0);
         tick();
      end
      out_ready = 1;
      wait_done(0);
      check("after hold in_ready", 32'(in_ready4), 32'd1);

      // clr after beat 2, with a beat presented during clr that must be dropped
      beat(0, 16'h1111, 1);
      beat(0, 16'h1111, 0);
      clr = 1; in_valid4 = 1; in_sum = 16'hFFFF; in_err = 1;
      tick();
      clr = 0; in_valid4 = 0; in_err = 0;
      check("clr result", 32'(result4), 32'h0);
      check("clr err", 32'(err4), 32'd0);
      check("clr in_ready", 32'(in_ready4), 32'd1);
      q4.push_back({1'b0, 16'h0020});
      repeat (4) beat(0, 16'h2222, 0);
      wait_done(0);

      // same with rst
      beat(0, 16'h1111, 1);
      beat(0, 16'h1111, 0);
      rst = 1;
      tick();
      rst = 0;
      check("rst result", 32'(result4), 32'h0);
      check("rst in_ready", 32'(in_ready4), 32'd1);
      q4.push_back({1'b0, 16'h0020});
      repeat (4) beat(0, 16'h2222, 0);
      wait_done(0);

      // rst in DONE discards the result
      out_ready = 0;
      repeat (4) beat(0, 16'h3333, 0);
      tick();
      check("pre-rst out_valid", 32'(out_valid4), 32'd1);
      rst = 1;
      tick();
      rst = 0;
      out_ready = 1;
      check("rst in DONE out_valid", 32'(out_valid4), 32'd0);
      tick(4);
      check("rst in DONE no output", 32'(out_valid4), 32'd0);

      // sixteen beats of 7777: 112 per lane overflows
`ifdef PSA_ACCUM_SAT_EN
      q16.push_back({1'b1, 16'h007C});
`else
      q16.push_back({1'b1, 16'hFFC0});
`endif
      repeat (16) beat(1, 16'h7777, 0);
      wait_done(1);

      tick(3);
      check("q4 drained", 32'(q4.size()), 32'd0);
      check("q16 drained", 32'(q16.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
